// File: rtl/byte_joining_param.sv
// Lane-to-stream serializer: captures a frame of LANES words and emits the first
// N words one per handshake in lane order, tagging each with its lane index and last flag.
module byte_joining_param #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int IDXW  = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] lanes_in,
    input  logic [IDXW:0]          lane_cnt,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDXW-1:0]        out_idx,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   cfg_err
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDXW:0] LANES_C = (IDXW+1)'(LANES);
    localparam logic [IDXW:0] ONE_C   = (IDXW+1)'(1);

    state_t                   state_q, state_d;
    logic [LANES*WIDTH-1:0]   hold_q, hold_d;
    logic [IDXW:0]            cnt_q, cnt_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     fire;
    logic                     at_last;
    logic                     cnt_ok;
    logic [IDXW:0]            cnt_eff;

    // Out-of-range counts fall back to the full physical width.
    assign cnt_ok  = (lane_cnt != '0) && (lane_cnt <= LANES_C);
    assign cnt_eff = cnt_ok ? lane_cnt : LANES_C;
    assign at_last = ({1'b0, idx_q} == (cnt_q - ONE_C));
    assign fire    = out_valid && out_ready;
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        if (accept) begin
            // A new frame always restarts at lane 0, even when it overlaps the last-word handshake.
            state_d = SEND;
            hold_d  = lanes_in;
            cnt_d   = cnt_eff;
            idx_d   = '0;
            err_d   = !cnt_ok;
        end else if (fire) begin
            if (out_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == SEND);
        out_last  = (state_q == SEND) && at_last;
        out_idx   = idx_q;
        out_data  = hold_q[idx_q*WIDTH +: WIDTH];
        cfg_err   = err_q;
        in_ready  = !reset && ((state_q == IDLE) || (out_valid && out_ready && out_last));
    end

endmodule

// File: tb/tb_byte_joining_param.sv
// Bench for byte_joining_param: directed frames on a 4x8 instance and a back-pressured
// frame stream on an 8x10 instance, each checked by its own scoreboard monitor.
module tb_byte_joining_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: LANES=4, WIDTH=8
    logic [31:0] a_lanes;
    logic [2:0]  a_cnt;
    logic        a_iv, a_ir, a_ol, a_ov, a_or, a_err;
    logic [7:0]  a_od;
    logic [1:0]  a_oi;

    // Instance B: LANES=8, WIDTH=10
    logic [79:0] b_lanes;
    logic [3:0]  b_cnt;
    logic        b_iv, b_ir, b_ol, b_ov, b_or, b_err;
    logic [9:0]  b_od;
    logic [2:0]  b_oi;
    logic        b_rand_en = 1'b0;

    byte_joining_param #(.WIDTH(8), .LANES(4)) dut_a (
        .clk(clk), .reset(reset), .lanes_in(a_lanes), .lane_cnt(a_cnt), .in_valid(a_iv),
        .in_ready(a_ir), .out_data(a_od), .out_idx(a_oi), .out_last(a_ol), .out_valid(a_ov),
        .out_ready(a_or), .cfg_err(a_err));

    byte_joining_param #(.WIDTH(10), .LANES(8)) dut_b (
        .clk(clk), .reset(reset), .lanes_in(b_lanes), .lane_cnt(b_cnt), .in_valid(b_iv),
        .in_ready(b_ir), .out_data(b_od), .out_idx(b_oi), .out_last(b_ol), .out_valid(b_ov),
        .out_ready(b_or), .cfg_err(b_err));

    int vecs = 0;
    int errs = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        vecs++;
        errs++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard monitors: sample well after the negedge input updates, before the posedge.
    always @(negedge clk) begin
        #3;
        if (!reset) begin
            if (a_ov && a_or) begin
                if (qa.size() == 0) flag_fail("a_unexpected_word");
                else chk("a_word", {21'b0, a_ol, a_oi, a_od}, qa.pop_front());
                chk("a_in_ready_on_handshake", {31'b0, a_ir}, {31'b0, a_ol});
            end else if (a_ov) begin
                chk("a_in_ready_stall", {31'b0, a_ir}, 32'd0);
            end
            if (b_ov && b_or) begin
                if (qb.size() == 0) flag_fail("b_unexpected_word");
                else chk("b_word", {18'b0, b_ol, b_oi, b_od}, qb.pop_front());
            end
        end
    end

    always @(negedge clk) b_or = b_rand_en ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic send_a(input logic [31:0] lanes, input logic [2:0] cnt);
        int n;
        int g;
        logic [1:0] ki;
        n = (cnt == 0 || cnt > 4) ? 4 : int'(cnt);
        a_lanes = lanes; a_cnt = cnt; a_iv = 1'b1;
        #1;
        g = 0;
        while (!a_ir && g < 200) begin @(negedge clk); #1; g++; end
        if (!a_ir) begin
            flag_fail("a_accept_timeout");
            a_iv = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            ki = k[1:0];
            qa.push_back({21'b0, (k == n - 1), ki, lanes[k*8 +: 8]});
        end
        @(negedge clk);
        a_iv = 1'b0;
        #1 chk("a_cfg_err_after_accept", {31'b0, a_err}, {31'b0, (cnt == 0 || cnt > 4)});
    endtask

    task automatic send_b(input logic [79:0] lanes, input logic [3:0] cnt);
        int n;
        int g;
        logic [2:0] ki;
        n = (cnt == 0 || cnt > 8) ? 8 : int'(cnt);
        b_lanes = lanes; b_cnt = cnt; b_iv = 1'b1;
        #1;
        g = 0;
        while (!b_ir && g < 300) begin @(negedge clk); #1; g++; end
        if (!b_ir) begin
            flag_fail("b_accept_timeout");
            b_iv = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            ki = k[2:0];
            qb.push_back({18'b0, (k == n - 1), ki, lanes[k*10 +: 10]});
        end
        @(negedge clk);
        b_iv = 1'b0;
        #1 chk("b_cfg_err_after_accept", {31'b0, b_err}, {31'b0, (cnt == 0 || cnt > 8)});
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((qa.size() != 0 || qb.size() != 0) && g < 2000) begin @(negedge clk); g++; end
        if (qa.size() != 0 || qb.size() != 0) flag_fail("drain_timeout");
        @(negedge clk);
        #1;
    endtask

    logic [79:0] rl;
    time t0, t1;

    initial begin
        a_lanes = '0; a_cnt = '0; a_iv = 1'b0; a_or = 1'b1;
        b_lanes = '0; b_cnt = '0; b_iv = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_a_out_valid", {31'b0, a_ov}, 32'd0);
        chk("rst_a_in_ready", {31'b0, a_ir}, 32'd0);
        chk("rst_a_out_data", {24'b0, a_od}, 32'd0);
        chk("rst_a_out_idx_last_err", {29'b0, a_oi, a_ol | a_err}, 32'd0);
        #1 reset = 1'b0;
        #1 chk("in_ready_after_reset", {31'b0, a_ir}, 32'd1);
        @(negedge clk);

        // Basic 4-lane frame, full throughput downstream
        send_a(32'h33221100, 3'd4);
        for (int k = 0; k < 4; k++) begin
            chk("seq4_valid", {31'b0, a_ov}, 32'd1);
            chk("seq4_idx", {30'b0, a_oi}, k);
            chk("seq4_data", {24'b0, a_od}, 32'h11 * k);
            chk("seq4_last", {31'b0, a_ol}, {31'b0, (k == 3)});
            @(negedge clk); #1;
        end
        chk("seq4_idle_after", {31'b0, a_ov}, 32'd0);

        // Back-to-back 2-lane frames with no bubble
        send_a(32'hEEEEA1A0, 3'd2);
        send_a(32'hEEEEB1B0, 3'd2);
        chk("b2b_no_gap_valid", {31'b0, a_ov}, 32'd1);
        chk("b2b_no_gap_data", {24'b0, a_od}, 32'hB0);
        drain();

        // Downstream stall on word 1
        send_a(32'h4D4C4B4A, 3'd4);
        @(negedge clk);
        a_or = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_idx", {30'b0, a_oi}, 32'd1);
            chk("stall_data", {24'b0, a_od}, 32'h4B);
            chk("stall_in_ready", {31'b0, a_ir}, 32'd0);
            @(negedge clk);
        end
        a_or = 1'b1;
        drain();

        // Illegal lane counts fall back to 4 words with a one-cycle error pulse
        send_a(32'h57565554, 3'd0);
        @(negedge clk); #1 chk("err0_pulse_width", {31'b0, a_err}, 32'd0);
        drain();
        send_a(32'h67666564, 3'd7);
        @(negedge clk); #1 chk("err7_pulse_width", {31'b0, a_err}, 32'd0);
        drain();

        // Single-word frames at one frame per cycle
        t0 = $time;
        for (int k = 0; k < 4; k++) send_a({24'h0, 8'hC0 + 8'(k)}, 3'd1);
        t1 = $time;
        chk("n1_throughput_cycles", 32'((t1 - t0) / 10), 32'd4);
        drain();

        // Asynchronous reset mid-frame
        send_a(32'h93929190, 3'd4);
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre_reset_idx", {30'b0, a_oi}, 32'd2);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, a_ov}, 32'd0);
        chk("async_rst_idx", {30'b0, a_oi}, 32'd0);
        chk("async_rst_in_ready", {31'b0, a_ir}, 32'd0);
        qa.delete();
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("in_ready_after_rerelease", {31'b0, a_ir}, 32'd1);
        @(negedge clk);
        send_a(32'hA3A2A1A0, 3'd4);
        chk("fresh_frame_idx0", {22'b0, a_oi, a_od}, 32'h0A0);
        drain();

        // Wider instance under random back-pressure and lane counts
        b_rand_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 8; k++) rl[k*10 +: 10] = 10'($urandom);
            send_b(rl, 4'($urandom_range(0, 15)));
        end
        drain();
        b_rand_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
